// File: rtl/trng_seed_fetch.sv
// TRNG seed fetcher: polls the TRNG status register, drains NUM_WORDS entropy words into a seed, presents it via valid/ack.
// Optional repetition health test enabled by defining TRNG_SEED_FETCH_HEALTH_EN.
module trng_seed_fetch #(
   parameter int NUM_WORDS = 8,
   parameter int POLL_GAP  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     seed_valid,
   input  logic                     seed_ack,
   output logic [32*NUM_WORDS-1:0]  seed_data,
   output logic [7:0]               health_fail_count,
   output logic                     trng_cs,
   output logic                     trng_we,
   output logic [7:0]               trng_address,
   output logic [31:0]              trng_write_data,
   input  logic [31:0]              trng_read_data,
   input  logic                     trng_ready
);

   localparam logic [7:0] ADDR_STATUS  = 8'h09;
   localparam logic [7:0] ADDR_ENTROPY = 8'h20;
   localparam logic [3:0] LAST_WORD    = 4'(NUM_WORDS - 1);
   localparam logic [7:0] GAP_LOAD     = 8'(POLL_GAP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POLL,
      S_GAP,
      S_READ,
      S_DONE
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     r_cs;
   logic                     w_cs_nxt;
   logic [7:0]               r_addr;
   logic [7:0]               w_addr_nxt;
   logic [7:0]               r_gap;
   logic [7:0]               w_gap_nxt;
   logic [3:0]               r_word_ctr;
   logic [3:0]               w_word_ctr_nxt;
   logic [32*NUM_WORDS-1:0]  r_seed;
   logic                     w_capture;
   logic                     w_reject;
   logic                     w_repeat;

`ifdef TRNG_SEED_FETCH_HEALTH_EN
   logic [31:0] r_prev_word;
   logic        r_prev_valid;
   logic [7:0]  r_fail_cnt;

   assign w_repeat = r_prev_valid && (trng_read_data == r_prev_word);

   // History spans seeds on purpose: a stuck source must not slip through at a seed boundary.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_prev_word  <= '0;
         r_prev_valid <= 1'b0;
         r_fail_cnt   <= '0;
      end else begin
         if (w_capture) begin
            r_prev_word  <= trng_read_data;
            r_prev_valid <= 1'b1;
         end
         if (w_reject && (r_fail_cnt != 8'hFF)) begin
            r_fail_cnt <= r_fail_cnt + 8'd1;
         end
      end
   end

   assign health_fail_count = r_fail_cnt;
`else
   assign w_repeat          = 1'b0;
   assign health_fail_count = 8'd0;
`endif

   // NOTE: every signal gets its default before the case so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_cs_nxt       = r_cs;
      w_addr_nxt     = r_addr;
      w_gap_nxt      = r_gap;
      w_word_ctr_nxt = r_word_ctr;
      w_capture      = 1'b0;
      w_reject       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt    = S_POLL;
               w_word_ctr_nxt = 4'd0;
            end
         end
         S_POLL: begin
            if (!r_cs) begin
               w_cs_nxt   = 1'b1;
               w_addr_nxt = ADDR_STATUS;
            end else if (trng_ready) begin
               w_cs_nxt = 1'b0;
               if (trng_read_data[0]) begin
                  w_state_nxt = S_READ;
               end else begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = GAP_LOAD;
               end
            end
         end
         S_GAP: begin
            // GAP lasts POLL_GAP cycles, with a floor of one cycle.
            if (r_gap > 8'd1) begin
               w_gap_nxt = r_gap - 8'd1;
            end else begin
               w_gap_nxt   = 8'd0;
               w_state_nxt = S_POLL;
            end
         end
         S_READ: begin
            if (!r_cs) begin
               w_cs_nxt   = 1'b1;
               w_addr_nxt = ADDR_ENTROPY;
            end else if (trng_ready) begin
               w_cs_nxt    = 1'b0;
               w_state_nxt = S_POLL;
               if (w_repeat) begin
                  w_reject = 1'b1;
               end else begin
                  w_capture = 1'b1;
                  if (r_word_ctr == LAST_WORD) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_word_ctr_nxt = r_word_ctr + 4'd1;
                  end
               end
            end
         end
         S_DONE: begin
            if (seed_ack) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cs_nxt    = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cs       <= 1'b0;
         r_addr     <= 8'h00;
         r_gap      <= 8'h00;
         r_word_ctr <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cs       <= w_cs_nxt;
         r_addr     <= w_addr_nxt;
         r_gap      <= w_gap_nxt;
         r_word_ctr <= w_word_ctr_nxt;
      end
   end

   // NOTE: the seed store is reset deliberately so a partial seed never leaks after an abort.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_seed <= '0;
      end else begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (w_capture && (r_word_ctr == 4'(k))) begin
               r_seed[32*k +: 32] <= trng_read_data;
            end
         end
      end
   end

   assign busy            = (r_state != S_IDLE);
   assign seed_valid      = (r_state == S_DONE);
   assign seed_data       = r_seed;
   assign trng_cs         = r_cs;
   assign trng_address    = r_addr;
   assign trng_we         = 1'b0;
   assign trng_write_data = 32'h0;

endmodule

// File: tb/tb_trng_seed_fetch.sv
// Scoreboard bench for trng_seed_fetch (NUM_WORDS=2, POLL_GAP=4) with a behavioural TRNG register model.
`timescale 1ns/1ps
module tb_trng_seed_fetch;

   localparam int NW       = 2;
   localparam int GAP      = 4;
   localparam int MAX_WAIT = 300;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic             busy;
   logic             seed_valid;
   logic             seed_ack;
   logic [32*NW-1:0] seed_data;
   logic [7:0]       health_fail_count;
   logic             trng_cs;
   logic             trng_we;
   logic [7:0]       trng_address;
   logic [31:0]      trng_write_data;
   logic [31:0]      trng_read_data;
   logic             trng_ready;

   always #5 clk = ~clk;

   trng_seed_fetch #(.NUM_WORDS(NW), .POLL_GAP(GAP)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .busy              (busy),
      .seed_valid        (seed_valid),
      .seed_ack          (seed_ack),
      .seed_data         (seed_data),
      .health_fail_count (health_fail_count),
      .trng_cs           (trng_cs),
      .trng_we           (trng_we),
      .trng_address      (trng_address),
      .trng_write_data   (trng_write_data),
      .trng_read_data    (trng_read_data),
      .trng_ready        (trng_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- TRNG model ----------------
   logic        model_clr;
   int          ws;
   logic [31:0] ent_mem [16];
   logic        stat_mem [16];
   int          stat_n;
   logic [3:0]  ent_idx;
   logic [3:0]  stat_idx;
   int          wait_ctr;
   logic        status_bit;

   assign status_bit     = (int'(stat_idx) < stat_n) ? stat_mem[stat_idx] : 1'b1;
   assign trng_ready     = trng_cs && (wait_ctr == ws);
   assign trng_read_data = !trng_ready ? 32'hDEAD_BEEF :
                           (trng_address == 8'h09) ? {31'b0, status_bit} : ent_mem[ent_idx];

   always @(posedge clk) begin
      if (model_clr) begin
         ent_idx  <= '0;
         stat_idx <= '0;
         wait_ctr <= 0;
      end else begin
         wait_ctr <= (trng_cs && !trng_ready) ? wait_ctr + 1 : 0;
         if (trng_cs && trng_ready) begin
            if (trng_address == 8'h09) stat_idx <= stat_idx + 4'd1;
            else                       ent_idx  <= ent_idx + 4'd1;
         end
      end
   end

   // ---------------- bus observer ----------------
   int         cyc = 0;
   int         n_stat;
   int         n_ent;
   int         stat_time [16];
   int         cs_len;
   logic       hold_pending = 1'b0;
   logic [7:0] hold_addr;

   always @(negedge clk) begin
      cyc++;
      if (model_clr) begin
         n_stat = 0; n_ent = 0; cs_len = 0; hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("bus_hold_cs", trng_cs, 1);
            check("bus_hold_addr", trng_address, hold_addr);
         end
         hold_pending = trng_cs && !trng_ready && reset_n;
         hold_addr    = trng_address;
         if (!busy) check("cs_low_idle", trng_cs, 0);
         if (trng_cs) cs_len++;
         else         cs_len = 0;
         if (trng_cs && trng_ready) begin
            check("cs_len", cs_len, ws + 1);
            if (trng_address == 8'h09) begin
               if (n_stat < 16) stat_time[n_stat] = cyc;
               n_stat++;
            end else begin
               n_ent++;
            end
            cs_len = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [63:0] seed;
      logic [7:0]  hcnt;
   } exp_t;
   exp_t exp_q[$];
   logic mon_seen = 1'b0;

   always @(negedge clk) begin
      if (seed_valid && !mon_seen) begin
         mon_seen = 1'b1;
         check("sb_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("seed_data", seed_data, e.seed);
            check("health_cnt", health_fail_count, e.hcnt);
         end
      end
      if (!seed_valid) mon_seen = 1'b0;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      model_clr = 1'b1;
      tick();
      model_clr = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!seed_valid && cycles < MAX_WAIT) begin
         tick();
         cycles++;
      end
      check("valid_timeout", seed_valid, 1);
   endtask

   task automatic do_ack();
      seed_ack = 1'b1;
      tick();
      seed_ack = 1'b0;
      check("valid_after_ack", seed_valid, 0);
      check("busy_after_ack", busy, 0);
   endtask

   task automatic push_exp(input logic [63:0] s, input logic [7:0] h);
      exp_t e;
      e.seed = s;
      e.hcnt = h;
      exp_q.push_back(e);
   endtask

   initial begin
      int   lat;
      int   guard;
      logic [63:0] h_seed;
      logic [7:0]  h_cnt;

      reset_n   = 1'b0;
      start     = 1'b0;
      seed_ack  = 1'b0;
      model_clr = 1'b1;
      ws        = 0;
      stat_n    = 0;
      for (int i = 0; i < 16; i++) begin
         ent_mem[i]  = 32'h0;
         stat_mem[i] = 1'b1;
      end
      repeat (3) tick();

      // Reset values
      check("rst_busy", busy, 0);
      check("rst_valid", seed_valid, 0);
      check("rst_seed", seed_data, 0);
      check("rst_hcnt", health_fail_count, 0);
      check("rst_cs", trng_cs, 0);
      check("rst_addr", trng_address, 0);
      check("rst_we", trng_we, 0);
      check("rst_wdata", trng_write_data, 0);
      reset_n   = 1'b1;
      model_clr = 1'b0;
      tick();

      // Basic fetch with an always-ready TRNG: 4 cycles per word.
      clear_model();
      ent_mem[0] = 32'hA5A5_0001;
      ent_mem[1] = 32'hA5A5_0002;
      push_exp(64'hA5A5_0002_A5A5_0001, 8'd0);
      pulse_start();
      check("busy_after_start", busy, 1);
      wait_valid(lat);
      check("seed_latency", lat, 8);
      repeat (3) tick();
      check("valid_held", seed_valid, 1);
      do_ack();
      check("basic_stat_reads", n_stat, 2);
      check("basic_ent_reads", n_ent, 2);

      // Not-ready polling: three not-ready status reads before the first word.
      clear_model();
      stat_n      = 4;
      stat_mem[0] = 1'b0;
      stat_mem[1] = 1'b0;
      stat_mem[2] = 1'b0;
      stat_mem[3] = 1'b1;
      ent_mem[0]  = 32'h0BAD_F00D;
      ent_mem[1]  = 32'hC0DE_0002;
      push_exp(64'hC0DE_0002_0BAD_F00D, 8'd0);
      pulse_start();
      wait_valid(lat);
      do_ack();
      check("poll_stat_reads", n_stat, 5);
      check("poll_ent_reads", n_ent, 2);
      // Between not-ready reads: GAP cycles, one cs-assert cycle, then the read cycle itself.
      for (int i = 0; i < 3; i++) check("poll_gap_spacing", stat_time[i+1] - stat_time[i], GAP + 2);
      stat_n = 0;

      // Wait states: 3 not-ready cycles per transaction; observer checks bus stability.
      clear_model();
      ws         = 3;
      ent_mem[0] = 32'h1111_2222;
      ent_mem[1] = 32'h3333_4444;
      push_exp(64'h3333_4444_1111_2222, 8'd0);
      pulse_start();
      wait_valid(lat);
      check("ws_latency", lat, 8 + 4 * 3);
      do_ack();
      ws = 0;

      // Ignored starts: during POLL, during DONE, and together with ack.
      clear_model();
      ent_mem[0] = 32'h5555_0001;
      ent_mem[1] = 32'h5555_0002;
      push_exp(64'h5555_0002_5555_0001, 8'd0);
      pulse_start();
      tick();
      pulse_start();
      wait_valid(lat);
      pulse_start();
      check("valid_after_done_start", seed_valid, 1);
      start    = 1'b1;
      seed_ack = 1'b1;
      tick();
      start    = 1'b0;
      seed_ack = 1'b0;
      check("valid_after_start_ack", seed_valid, 0);
      repeat (20) tick();
      check("ign_busy", busy, 0);
      check("ign_ent_reads", n_ent, 2);

      // Reset during an ENTROPY read.
      clear_model();
      ws         = 5;
      ent_mem[0] = 32'h3C3C_0001;
      ent_mem[1] = 32'h3C3C_0002;
      pulse_start();
      guard = 0;
      while (!(trng_cs && trng_address == 8'h20) && guard < MAX_WAIT) begin
         tick();
         guard++;
      end
      check("read_reached", trng_cs && trng_address == 8'h20, 1);
      reset_n = 1'b0;
      tick();
      check("midrst_cs", trng_cs, 0);
      check("midrst_busy", busy, 0);
      check("midrst_seed", seed_data, 0);
      check("midrst_valid", seed_valid, 0);
      reset_n = 1'b1;
      ws      = 0;
      clear_model();
      push_exp(64'h3C3C_0002_3C3C_0001, 8'd0);
      pulse_start();
      wait_valid(lat);
      do_ack();

      // Repetition health test.
      clear_model();
      ent_mem[0] = 32'h1234_5678;
      ent_mem[1] = 32'h1234_5678;
      ent_mem[2] = 32'h0000_0001;
`ifdef TRNG_SEED_FETCH_HEALTH_EN
      h_seed = 64'h0000_0001_1234_5678;
      h_cnt  = 8'd1;
`else
      h_seed = 64'h1234_5678_1234_5678;
      h_cnt  = 8'd0;
`endif
      push_exp(h_seed, h_cnt);
      pulse_start();
      wait_valid(lat);
      do_ack();

      repeat (3) tick();
      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
